// File: rtl/mem_bus_master.sv
// Request/response front end that turns byte or 16-bit little-endian requests
// into byte-wide accesses on a simple strobed memory port.
module mem_bus_master #(
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_word,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_ce,
    output logic        mem_r,
    output logic        mem_w,
    output logic        mem_oe,
    output logic        mem_rst,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1,
        RESP
    } state_t;

    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] WAIT_LAST = 2'(WAIT_CYC);

    state_t      state_reg, state_next;
    logic [1:0]  wait_cnt_reg, wait_cnt_next;
    logic [1:0]  op_reg, op_next;
    logic        word_reg, word_next;
    logic [15:0] addr_reg, addr_next;
    logic [15:0] wdata_reg, wdata_next;
    logic [15:0] rdata_reg, rdata_next;

    logic        in_byte;
    logic        byte_done;
    logic        is_write;
    logic        is_clear;
    logic        is_read;

    assign in_byte   = (state_reg == BYTE0) || (state_reg == BYTE1);
    assign byte_done = (wait_cnt_reg == WAIT_LAST);
    assign is_write  = (op_reg == OP_WRITE);
    assign is_clear  = (op_reg == OP_CLEAR);
    // The reserved encoding falls through to read behaviour.
    assign is_read   = !is_write && !is_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 2'd0;
            op_reg       <= 2'd0;
            word_reg     <= 1'b0;
            addr_reg     <= 16'h0000;
            wdata_reg    <= 16'h0000;
            rdata_reg    <= 16'h0000;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            op_reg       <= op_next;
            word_reg     <= word_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        op_next       = op_reg;
        word_next     = word_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        rdata_next    = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next    = BYTE0;
                    wait_cnt_next = 2'd0;
                    op_next       = req_op;
                    word_next     = req_word;
                    addr_next     = req_addr;
                    wdata_next    = req_wdata;
                    rdata_next    = 16'h0000;
                end
            end
            BYTE0: begin
                if (byte_done) begin
                    if (is_read) begin
                        rdata_next[7:0] = mem_rdata;
                    end
                    state_next    = word_reg ? BYTE1 : RESP;
                    wait_cnt_next = 2'd0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            BYTE1: begin
                if (byte_done) begin
                    if (is_read) begin
                        rdata_next[15:8] = mem_rdata;
                    end
                    state_next    = RESP;
                    wait_cnt_next = 2'd0;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 2'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req_ready  = (state_reg == IDLE);
    assign busy       = !req_ready;
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;

    // Second byte address wraps naturally in 16 bits.
    assign mem_addr  = !in_byte ? 16'h0000 :
                       (state_reg == BYTE1) ? (addr_reg + 16'd1) : addr_reg;
    assign mem_wdata = !(in_byte && is_write) ? 8'h00 :
                       (state_reg == BYTE1) ? wdata_reg[15:8] : wdata_reg[7:0];

    // Strobes drop immediately with rst so an aborted access never lands.
    assign mem_ce  = in_byte && !rst;
    assign mem_r   = in_byte && is_read  && !rst;
    assign mem_oe  = in_byte && is_read  && !rst;
    assign mem_w   = in_byte && is_write && !rst;
    assign mem_rst = in_byte && is_clear && !rst;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (WAIT_CYC 0 and 2) against a
// transaction-level byte-array model and a per-cycle timing expectation.
module tb_mem_bus_master;

    localparam int N = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid  [N];
    logic        req_ready  [N];
    logic [1:0]  req_op     [N];
    logic        req_word   [N];
    logic [15:0] req_addr   [N];
    logic [15:0] req_wdata  [N];
    logic        resp_valid [N];
    logic [15:0] resp_rdata [N];
    logic        busy       [N];
    logic [15:0] mem_addr   [N];
    logic [7:0]  mem_wdata  [N];
    logic        mem_ce     [N];
    logic        mem_r      [N];
    logic        mem_w      [N];
    logic        mem_oe     [N];
    logic        mem_rst    [N];
    logic [7:0]  mem_rdata  [N];

    logic [7:0]  ref_mem    [N][65536];
    logic [15:0] last_rdata [N];

    int checks = 0;
    int errors = 0;

    // Background contents so unwritten locations are not trivially zero.
    function automatic logic [7:0] pat(input int idx, input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A ^ 8'(idx);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            bit [7:0] dmem [65536];

            mem_bus_master #(.WAIT_CYC(2 * gi)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .req_valid  (req_valid[gi]),
                .req_ready  (req_ready[gi]),
                .req_op     (req_op[gi]),
                .req_word   (req_word[gi]),
                .req_addr   (req_addr[gi]),
                .req_wdata  (req_wdata[gi]),
                .resp_valid (resp_valid[gi]),
                .resp_rdata (resp_rdata[gi]),
                .busy       (busy[gi]),
                .mem_addr   (mem_addr[gi]),
                .mem_wdata  (mem_wdata[gi]),
                .mem_ce     (mem_ce[gi]),
                .mem_r      (mem_r[gi]),
                .mem_w      (mem_w[gi]),
                .mem_oe     (mem_oe[gi]),
                .mem_rst    (mem_rst[gi]),
                .mem_rdata  (mem_rdata[gi])
            );

            assign mem_rdata[gi] = dmem[mem_addr[gi]] ^ pat(gi, mem_addr[gi]);

            always @(posedge clk) begin
                if (mem_ce[gi] && mem_w[gi])
                    dmem[mem_addr[gi]] <= mem_wdata[gi] ^ pat(gi, mem_addr[gi]);
                else if (mem_ce[gi] && mem_rst[gi])
                    dmem[mem_addr[gi]] <= pat(gi, mem_addr[gi]);
            end
        end
    endgenerate

    task automatic check(input string tag, input int idx,
                         input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", tag, idx, got, exp);
        end
    endtask

    function automatic logic [15:0] strobes(input int idx);
        return {11'd0, mem_ce[idx], mem_r[idx], mem_w[idx], mem_oe[idx], mem_rst[idx]};
    endfunction

    task automatic check_idle_outputs(input int idx);
        check("req_ready", idx, {15'd0, req_ready[idx]}, 16'd1);
        check("busy", idx, {15'd0, busy[idx]}, 16'd0);
        check("resp_valid", idx, {15'd0, resp_valid[idx]}, 16'd0);
        check("strobes", idx, strobes(idx), 16'd0);
        check("mem_addr", idx, mem_addr[idx], 16'h0000);
        check("mem_wdata", idx, {8'd0, mem_wdata[idx]}, 16'h0000);
        check("resp_rdata", idx, resp_rdata[idx], last_rdata[idx]);
    endtask

    task automatic idle_cycles(input int idx, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            check_idle_outputs(idx);
        end
    endtask

    // Presents one request, then checks every cycle up to and including the
    // response against the timing rule (WAIT_CYC+1) cycles per byte + 1.
    task automatic do_req(input int idx, input logic [1:0] op, input logic word,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic hold, input int exp_wait);
        int per, nb, lat, n, b;
        logic r, w, c;
        logic [15:0] a1, ea, exp_rd;
        logic [4:0]  exp_stb;
        logic [7:0]  exp_wd;
        per = 2 * idx + 1;
        nb  = word ? 2 : 1;
        lat = nb * per + 1;
        a1  = addr + 16'd1;
        w   = (op == 2'b01);
        c   = (op == 2'b10);
        r   = !w && !c;
        exp_rd = 16'h0000;
        if (r) begin
            exp_rd[7:0] = ref_mem[idx][addr];
            if (word) exp_rd[15:8] = ref_mem[idx][a1];
        end

        req_op[idx]    = op;
        req_word[idx]  = word;
        req_addr[idx]  = addr;
        req_wdata[idx] = wdata;
        req_valid[idx] = 1'b1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", idx, 16'(n), 16'(exp_wait));
        if (n >= 20) begin
            req_valid[idx] = 1'b0;
            return;
        end

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) req_valid[idx] = 1'b0;
            if (k <= nb * per) begin
                b       = (k - 1) / per;
                ea      = (b == 1) ? a1 : addr;
                exp_stb = {1'b1, r, w, r, c};
                exp_wd  = !w ? 8'h00 : (b == 1) ? wdata[15:8] : wdata[7:0];
            end else begin
                ea      = 16'h0000;
                exp_stb = 5'd0;
                exp_wd  = 8'h00;
            end
            check("mem_addr", idx, mem_addr[idx], ea);
            check("strobes", idx, strobes(idx), {11'd0, exp_stb});
            check("mem_wdata", idx, {8'd0, mem_wdata[idx]}, {8'd0, exp_wd});
            check("resp_valid", idx, {15'd0, resp_valid[idx]}, {15'd0, k == lat});
            check("req_ready", idx, {15'd0, req_ready[idx]}, 16'd0);
            check("busy", idx, {15'd0, busy[idx]}, 16'd1);
        end
        check("resp_rdata", idx, resp_rdata[idx], exp_rd);

        if (w) begin
            ref_mem[idx][addr] = wdata[7:0];
            if (word) ref_mem[idx][a1] = wdata[15:8];
        end else if (c) begin
            ref_mem[idx][addr] = 8'h00;
            if (word) ref_mem[idx][a1] = 8'h00;
        end
        last_rdata[idx] = exp_rd;
        $display("dut%0d op %0d word %0d addr %h wdata %h rdata %h",
                 idx, op, word, addr, wdata, resp_rdata[idx]);
    endtask

    task automatic req(input int idx, input logic [1:0] op, input logic word,
                       input logic [15:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        do_req(idx, op, word, addr, wdata, 1'b0, 0);
    endtask

    task automatic run_tests(input int idx);
        logic [15:0] a, d;
        logic [1:0]  op;
        logic        wd;

        req(idx, 2'b01, 1'b0, 16'h0010, 16'h00A5);
        req(idx, 2'b00, 1'b0, 16'h0010, 16'h0000);
        req(idx, 2'b01, 1'b1, 16'h0100, 16'hBEEF);
        req(idx, 2'b00, 1'b1, 16'h0100, 16'h0000);
        req(idx, 2'b01, 1'b1, 16'hFFFF, 16'h1234);
        req(idx, 2'b00, 1'b1, 16'hFFFF, 16'h0000);
        req(idx, 2'b00, 1'b0, 16'h0000, 16'h0000);
        req(idx, 2'b10, 1'b1, 16'h0020, 16'h0000);
        req(idx, 2'b00, 1'b1, 16'h0020, 16'h0000);
        req(idx, 2'b11, 1'b1, 16'h0100, 16'h0000);
        idle_cycles(idx, 2);

        // Abort a word write in its first cycle.
        @(negedge clk);
        req_op[idx]    = 2'b01;
        req_word[idx]  = 1'b1;
        req_addr[idx]  = 16'h0030;
        req_wdata[idx] = 16'hCAFE;
        req_valid[idx] = 1'b1;
        check("req_ready", idx, {15'd0, req_ready[idx]}, 16'd1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_strobes", idx, strobes(idx), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < N; j++) last_rdata[j] = 16'h0000;
        $display("dut%0d reset during word write 0030", idx);
        check_idle_outputs(idx);
        idle_cycles(idx, 3);
        req(idx, 2'b00, 1'b1, 16'h0030, 16'h0000);

        // Requester holds req_valid across three back-to-back requests.
        @(negedge clk);
        do_req(idx, 2'b01, 1'b0, 16'h0200, 16'h0011, 1'b1, 0);
        do_req(idx, 2'b01, 1'b1, 16'h0201, 16'h3322, 1'b1, 1);
        do_req(idx, 2'b00, 1'b1, 16'h0200, 16'h0000, 1'b1, 1);
        req_valid[idx] = 1'b0;
        idle_cycles(idx, 1);

        for (int t = 0; t < 30; t++) begin
            op = 2'($urandom_range(0, 3));
            wd = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 1) != 0) ? 16'hFFF8 : 16'h0040;
            a  = a + 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            req(idx, op, wd, a, d);
            idle_cycles(idx, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout dut- got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_valid[i]  = 1'b0;
            req_op[i]     = 2'b00;
            req_word[i]   = 1'b0;
            req_addr[i]   = 16'h0000;
            req_wdata[i]  = 16'h0000;
            last_rdata[i] = 16'h0000;
            for (int a = 0; a < 65536; a++) ref_mem[i][a] = pat(i, 16'(a));
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) check_idle_outputs(i);
        for (int i = 0; i < N; i++) run_tests(i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
